// File: rtl/clk_div_pkg.sv
// Shared constants for the clock divider generator.
package clk_div_pkg;

  // Default width of the base divider counter and of the divisor input.
  localparam int CNT_W_DEF   = 8;

  // Base half-period, in clk cycles, that is committed at reset.
  localparam int DIV_DEF     = 5;

  // Largest supported number of divided clock outputs.
  localparam int N_OUT_MAX   = 8;

  // Number of divided outputs when the caller does not override it.
  localparam int N_OUT_DEF   = 3;

endpackage : clk_div_pkg

// File: rtl/clk_div_gen_if.sv
// Control and output bundle of the clock divider generator.
interface clk_div_gen_if
  import clk_div_pkg::*;
#(
  parameter int N_OUT = N_OUT_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             enb;       // count enable, low freezes the divider
  logic             div_ld;    // one-cycle request to load div_val
  logic [CNT_W-1:0] div_val;   // new base half-period in clk cycles
  logic             sync;      // synchronous phase realign
  logic [N_OUT-1:0] clk_out;   // divided clocks, bit 0 fastest
  logic [N_OUT-1:0] rise_stb;  // pulse in the cycle clk_out[k] goes high
  logic             locked;    // outputs run at the committed ratio

  // Controller side: drives the requests, observes the clocks.
  modport master (
    output enb, div_ld, div_val, sync,
    input  clk_out, rise_stb, locked
  );

  // Divider side.
  modport slave (
    input  enb, div_ld, div_val, sync,
    output clk_out, rise_stb, locked
  );

endinterface : clk_div_gen_if

// File: rtl/clk_div_stage.sv
// One bit of the divided-clock chain: a toggle flop plus its rising-edge
// strobe. The chain of stages behaves as a down-counter, which keeps every
// rising edge aligned with the rising edges of the faster bits.
module clk_div_stage (
  input  logic clk,
  input  logic rst,
  input  logic clr,        // phase realign: force the bit low
  input  logic tick,       // base-counter terminal tick
  input  logic carry_in,   // every faster bit is currently 0
  output logic q,
  output logic rise,
  output logic carry_out
);

  logic q_q;
  logic rise_q;
  logic toggle;

  // This bit flips on a tick only when all faster bits are low.
  assign toggle    = tick & carry_in;
  assign carry_out = carry_in & ~q_q;
  assign q         = q_q;
  assign rise      = rise_q;

  // Output bit and its strobe; the strobe marks the 0->1 transition.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with <= so every flop samples the
    // pre-edge values of its neighbours, whatever the block order.
    if (rst) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
    end else if (clr) begin
      q_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      q_q    <= q_q ^ toggle;
      rise_q <= toggle & ~q_q;
    end
  end

endmodule : clk_div_stage

// File: rtl/clk_div_gen.sv
// Clock divider generator: a programmable base divider followed by a chain
// of halving stages. Divisor reloads are deferred to the next terminal tick
// so that no output half-period is ever shortened.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int N_OUT       = N_OUT_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEF
) (
  input  logic          clk,
  input  logic          rst,
  clk_div_gen_if.slave  bus
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DIV_DEFAULT - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic [CNT_W-1:0] div_q,      div_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic             pend_q,     pend_d;
  logic             locked_q,   locked_d;

  logic [CNT_W-1:0] ld_val;
  logic             tick;

  logic [N_OUT-1:0] carry;
  logic [N_OUT-1:0] clk_out_w;
  logic [N_OUT-1:0] rise_w;

  // A requested divisor of 0 behaves as 1 (toggle every enabled cycle).
  assign ld_val = (bus.div_val == '0) ? ONE : bus.div_val;

  // Terminal tick: last count of the current half-period. A realign
  // request pre-empts it so the outputs restart from a clean phase.
  assign tick = bus.enb && !bus.sync && (cnt_q == div_q - ONE);

  // Next-state for the base counter, committed divisor and reload state.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through
    // the decision tree can leave one unassigned and infer a latch.
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    locked_d   = locked_q;

    if (bus.sync) begin
      // Realign: the next cycle becomes a terminal tick. A simultaneous
      // load bypasses the pending register and takes effect at once.
      locked_d = 1'b0;
      if (bus.div_ld) begin
        div_d  = ld_val;
        cnt_d  = ld_val - ONE;
        pend_d = 1'b0;
      end else begin
        cnt_d  = div_q - ONE;
      end
    end else begin
      if (bus.enb) begin
        cnt_d = tick ? '0 : cnt_q + ONE;
      end
      if (tick) begin
        locked_d = 1'b1;
        if (pend_q) begin
          div_d  = pend_val_q;
          pend_d = 1'b0;
        end
      end
      // A load captured in this cycle waits for the following tick; a
      // second load before then simply overwrites the pending value.
      if (bus.div_ld) begin
        pend_val_d = ld_val;
        pend_d     = 1'b1;
        locked_d   = 1'b0;
      end
    end
  end

  // Divider state registers; reset also discards any pending reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= CNT_RST;
      div_q      <= DIV_RST;
      pend_val_q <= DIV_RST;
      pend_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      locked_q   <= locked_d;
    end
  end

  // The fastest stage always toggles on a tick.
  assign carry[0] = 1'b1;

  // Halving chain: stage k sees "all faster bits low" from stage k-1.
  for (genvar k = 0; k < N_OUT; k++) begin : g_stage
    if (k < N_OUT - 1) begin : g_mid
      clk_div_stage u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.sync),
        .tick      (tick),
        .carry_in  (carry[k]),
        .q         (clk_out_w[k]),
        .rise      (rise_w[k]),
        .carry_out (carry[k+1])
      );
    end else begin : g_last
      logic carry_end;
      clk_div_stage u_stage (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.sync),
        .tick      (tick),
        .carry_in  (carry[k]),
        .q         (clk_out_w[k]),
        .rise      (rise_w[k]),
        .carry_out (carry_end)
      );
    end
  end

  assign bus.clk_out  = clk_out_w;
  assign bus.rise_stb = rise_w;
  assign bus.locked   = locked_q;

endmodule : clk_div_gen

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter N_OUT, default 3: number of divided clock outputs, each half the rate of the previous one; legal range 1..8.
REQ-002 Parameter CNT_W, default 8: width of the base divider counter and of div_val.
REQ-003 Parameter DIV_DEFAULT, default 5: base half-period in clk cycles after reset.
REQ-004 clk  in  1  sole clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 enb  in  1  count enable; low freezes all state.
REQ-007 div_ld  in  1  one-cycle request to load div_val.
REQ-008 div_val  in  CNT_W  new base half-period in clk cycles.
REQ-009 sync  in  1  synchronous phase realign.
REQ-010 clk_out  out  N_OUT  divided clocks; bit 0 fastest, registered.
REQ-011 rise_stb  out  N_OUT  one-cycle pulse per bit, asserted in the cycle clk_out[k] becomes 1.
REQ-012 locked  out  1  outputs are running at the committed ratio.

Function
REQ-013 An internal committed divisor div_q SHALL hold the active value; div_val=0 SHALL be treated as 1.
REQ-014 The base counter SHALL count 0..div_q-1 while enb=1.
REQ-015 The cycle in which the counter equals div_q-1 with enb=1 is the terminal tick; on that cycle the counter SHALL wrap to 0.
REQ-016 On a terminal tick, clk_out[k] SHALL toggle iff clk_out[j]==0 for all j<k; clk_out[0] always toggles.
REQ-017 This produces periods of 2*div_q*2^k cycles, with all rising edges aligned.
REQ-018 rise_stb[k] SHALL be 1 exactly in the cycle that clk_out[k] registers 0->1, and 0 otherwise, including while enb=0.
REQ-019 enb=0 SHALL hold the counter, clk_out and locked unchanged.
REQ-020 div_ld=1 SHALL capture div_val into a pending register and set a pending flag.
REQ-021 A pending value SHALL be committed to div_q at the next terminal tick, so no output half-period is shortened; the new ratio applies from the following count.
REQ-022 A second div_ld while a load is pending SHALL overwrite the pending value; the last write wins.
REQ-023 sync=1 SHALL set counter=div_q-1, clk_out=0, rise_stb=0 and locked=0 on the next edge; div_q SHALL be kept.
REQ-024 If sync and div_ld are asserted together, div_val SHALL commit to div_q immediately and the counter SHALL take div_val-1 (0 if div_val<=1).
REQ-025 locked SHALL rise on the first terminal tick after reset or sync.
REQ-026 locked SHALL be 0 from the cycle after div_ld until the terminal tick that commits the load, and SHALL be 1 again after that tick.
REQ-027 rst SHALL take priority over sync, div_ld and enb.

Reset
REQ-028 rst=1 SHALL set: div_q=DIV_DEFAULT, counter=DIV_DEFAULT-1, clk_out=0, rise_stb=0, locked=0, pending flag=0.
REQ-029 The first enabled cycle after reset SHALL be a terminal tick: all clk_out bits rise and all rise_stb bits pulse.
REQ-030 rst asserted mid-period or mid-reload SHALL discard the pending load.

Structure
REQ-031 Package clk_div_pkg SHALL hold the CNT_W and DIV_DEFAULT default constants and the max-N_OUT constant.
REQ-032 One sub-module, clk_div_stage, SHALL implement a single toggle/strobe bit with inputs tick and carry_in and outputs q, rise and carry_out.
REQ-033 clk_div_stage SHALL be instantiated N_OUT times in a generate chain.

Verification
REQ-034 Defaults with enb=1 after rst -> clk_out[0] period 10, clk_out[1] period 20, clk_out[2] period 40 cycles; rise_stb[2] pulses every 40 cycles; all outputs rise together in cycle 1.
REQ-035 div_ld with div_val=2 at counter=1 -> old 5-cycle half-period completes; then clk_out[0] period 4; locked low for that interval.
REQ-036 div_val=0 -> clk_out[0] toggles every cycle and rise_stb[0] pulses every 2 cycles.
REQ-037 enb low for 7 cycles mid-period -> outputs frozen, no strobes; the period resumes stretched by exactly 7 cycles.
REQ-038 sync with div_ld (div_val=3) in the same cycle -> next cycle is a terminal tick with all outputs rising; clk_out[0] period 6.
REQ-039 rst during a pending reload -> div_q returns to 5 and the pending value is never applied.
